// File: rtl/wb_commit_stage_if.sv
`default_nettype none
//==============================================================================
//  Module      : wb_commit_stage_if
//  Description : Bundle of the write-back/commit stage signals. The upstream
//                MEM stage offers records (in_valid/in_ready) and the commit
//                sink accepts the head record (out_ready). The stage drives
//                the register-file write port, HI/LO, retire count and busy.
//  Modports    : master - MEM stage / commit sink side (drives requests)
//                slave  - commit stage side (wb_commit_stage)
//  Revision    : 1.0  initial release
//==============================================================================
interface wb_commit_stage_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 7
);
    // upstream record
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  aluout;
    logic [WIDTH-1:0]  memdata;
    logic              mem_to_reg;
    logic              reg_write;
    logic [ADDR_W-1:0] waddr;
    logic              exc_addr_sel;
    logic              exc_data_sel;
    logic [ADDR_W-1:0] exc_addr;
    logic [WIDTH-1:0]  exc_data;
    logic              hilo_we;
    logic [63:0]       hilo_data;
    logic [31:0]       pc_in;
    logic              flush;

    // commit side
    logic              out_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [WIDTH-1:0]  rf_wdata;
    logic [31:0]       pc_out;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;
    logic [31:0]       retire_cnt;
    logic              busy;

    modport master (
        output in_valid, aluout, memdata, mem_to_reg, reg_write, waddr,
               exc_addr_sel, exc_data_sel, exc_addr, exc_data,
               hilo_we, hilo_data, pc_in, flush, out_ready,
        input  in_ready, rf_we, rf_waddr, rf_wdata, pc_out,
               hi, lo, retire_cnt, busy
    );

    modport slave (
        input  in_valid, aluout, memdata, mem_to_reg, reg_write, waddr,
               exc_addr_sel, exc_data_sel, exc_addr, exc_data,
               hilo_we, hilo_data, pc_in, flush, out_ready,
        output in_ready, rf_we, rf_waddr, rf_wdata, pc_out,
               hi, lo, retire_cnt, busy
    );
endinterface
`default_nettype wire

// File: rtl/wb_commit_stage.sv
`default_nettype none
//==============================================================================
//  Module      : wb_commit_stage
//  Description : Write-back / commit stage. Records from the MEM stage are
//                resolved (result mux plus exception overrides) on push and
//                held in a small circular commit buffer. The head record is
//                committed when the sink is ready: register-file write,
//                optional HI/LO load, and retire counter increment.
//  Ports       : clk    - rising-edge clock
//                resetn - asynchronous active-low reset
//                bus    - wb_commit_stage_if.slave (record in, commit out)
//  Revision    : 1.0  initial release
//==============================================================================
module wb_commit_stage #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 2
) (
    input  wire                  clk,
    input  wire                  resetn,
    wb_commit_stage_if.slave     bus
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    // commit buffer storage (contents are don't-care until pushed)
    logic [WIDTH-1:0]  r_data    [DEPTH];
    logic [ADDR_W-1:0] r_addr    [DEPTH];
    logic              r_rwe     [DEPTH];
    logic              r_hilo_we [DEPTH];
    logic [63:0]       r_hilo    [DEPTH];
    logic [31:0]       r_pc      [DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [31:0]        r_retire_cnt;

    logic              w_busy;
    logic              w_in_ready;
    logic              w_push;
    logic              w_pop;
    logic [WIDTH-1:0]  w_push_data;
    logic [ADDR_W-1:0] w_push_addr;
    logic [WIDTH-1:0]  w_head_data;
    logic [ADDR_W-1:0] w_head_addr;
    logic              w_head_rwe;
    logic              w_head_hilo_we;
    logic [63:0]       w_head_hilo;
    logic [31:0]       w_head_pc;

    // Ready depends only on the registered count, so a full buffer stays
    // not-ready for the whole cycle even while its head is popping.
    assign w_busy     = (r_count != '0);
    assign w_in_ready = (r_count < c_DEPTH);

    // A flush discards everything not popping this cycle, including the
    // record being offered.
    assign w_push = bus.in_valid && w_in_ready && !bus.flush;
    assign w_pop  = w_busy && bus.out_ready;

    // Record resolution at push time: exception overrides win.
    assign w_push_data = bus.exc_data_sel ? bus.exc_data
                       : (bus.mem_to_reg ? bus.memdata : bus.aluout);
    assign w_push_addr = bus.exc_addr_sel ? bus.exc_addr : bus.waddr;

    // Head view is forced to zero when empty so stale entries never leak out.
    always_comb begin
        w_head_data    = '0;
        w_head_addr    = '0;
        w_head_rwe     = 1'b0;
        w_head_hilo_we = 1'b0;
        w_head_hilo    = '0;
        w_head_pc      = '0;
        if (w_busy) begin
            w_head_data    = r_data[r_rd_ptr];
            w_head_addr    = r_addr[r_rd_ptr];
            w_head_rwe     = r_rwe[r_rd_ptr];
            w_head_hilo_we = r_hilo_we[r_rd_ptr];
            w_head_hilo    = r_hilo[r_rd_ptr];
            w_head_pc      = r_pc[r_rd_ptr];
        end
    end

    // Entry storage: written only on push, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wr_ptr]    <= w_push_data;
            r_addr[r_wr_ptr]    <= w_push_addr;
            r_rwe[r_wr_ptr]     <= bus.reg_write;
            r_hilo_we[r_wr_ptr] <= bus.hilo_we;
            r_hilo[r_wr_ptr]    <= bus.hilo_data;
            r_pc[r_wr_ptr]      <= bus.pc_in;
        end
    end

    // Pointers, occupancy and architectural state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_retire_cnt <= '0;
        end else begin
            // A coincident pop still retires even when a flush is present.
            if (w_pop) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
                if (w_head_hilo_we) begin
                    r_hi <= WIDTH'(w_head_hilo[63:32]);
                    r_lo <= WIDTH'(w_head_hilo[31:0]);
                end
            end

            if (bus.flush) begin
                // No push can happen under flush, so the write pointer is
                // already final; collapse the read pointer onto it.
                r_count  <= '0;
                r_rd_ptr <= r_wr_ptr;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_W'(1);
                    2'b01:   r_count <= r_count - c_CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Commit outputs: r0 is hardwired, so writes to address 0 are dropped.
    assign bus.in_ready   = w_in_ready;
    assign bus.busy       = w_busy;
    assign bus.rf_we      = w_pop && w_head_rwe && (w_head_addr != '0);
    assign bus.rf_waddr   = w_head_addr;
    assign bus.rf_wdata   = w_head_data;
    assign bus.pc_out     = w_head_pc;
    assign bus.hi         = r_hi;
    assign bus.lo         = r_lo;
    assign bus.retire_cnt = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_stage.sv
`default_nettype none
//==============================================================================
//  Module      : tb_wb_commit_stage
//  Description : Self-checking bench for wb_commit_stage. A table of single
//                record commits is replayed, followed by hand-written
//                sequences for back-pressure, flush, counter wrap and reset.
//  Revision    : 1.0  initial release
//==============================================================================
module tb_wb_commit_stage;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 2;

    logic clk;
    logic resetn;

    wb_commit_stage_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    wb_commit_stage #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_retire = 32'd0;

    typedef struct {
        logic [31:0] aluout;
        logic [31:0] memdata;
        logic        mem_to_reg;
        logic        reg_write;
        logic [6:0]  waddr;
        logic        exc_addr_sel;
        logic        exc_data_sel;
        logic [6:0]  exc_addr;
        logic [31:0] exc_data;
        logic        hilo_we;
        logic [63:0] hilo_data;
        logic [31:0] pc;
        logic        exp_we;
        logic [6:0]  exp_waddr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid     = 1'b0;
        bus.aluout       = '0;
        bus.memdata      = '0;
        bus.mem_to_reg   = 1'b0;
        bus.reg_write    = 1'b0;
        bus.waddr        = '0;
        bus.exc_addr_sel = 1'b0;
        bus.exc_data_sel = 1'b0;
        bus.exc_addr     = '0;
        bus.exc_data     = '0;
        bus.hilo_we      = 1'b0;
        bus.hilo_data    = '0;
        bus.pc_in        = '0;
        bus.flush        = 1'b0;
    endtask

    // Offer a plain ALU-result record.
    task automatic offer(input logic [31:0] data, input logic [6:0] addr, input logic [31:0] pc);
        idle_inputs();
        bus.in_valid  = 1'b1;
        bus.aluout    = data;
        bus.reg_write = 1'b1;
        bus.waddr     = addr;
        bus.pc_in     = pc;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".rf_we"},      64'(bus.rf_we),      64'd0);
        check({tag, ".busy"},       64'(bus.busy),       64'd0);
        check({tag, ".in_ready"},   64'(bus.in_ready),   64'd1);
        check({tag, ".rf_waddr"},   64'(bus.rf_waddr),   64'd0);
        check({tag, ".rf_wdata"},   64'(bus.rf_wdata),   64'd0);
        check({tag, ".pc_out"},     64'(bus.pc_out),     64'd0);
        check({tag, ".hi"},         64'(bus.hi),         64'd0);
        check({tag, ".lo"},         64'(bus.lo),         64'd0);
        check({tag, ".retire_cnt"}, 64'(bus.retire_cnt), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //                 alu           mem          m2r  rw  waddr  eas eds eaddr  edata         hwe hilo                    pc            we  ewaddr ewdata        hi            lo
        vecs[0] = '{32'h11,       32'h22,      1'b0,1'b1,7'd5,  1'b0,1'b0,7'h00,32'h0,       1'b0,64'h0,                 32'h100,      1'b1,7'd5,  32'h11,       32'h0,        32'h0};
        vecs[1] = '{32'h33,       32'hCAFE,    1'b1,1'b1,7'd9,  1'b0,1'b0,7'h00,32'h0,       1'b0,64'h0,                 32'h104,      1'b1,7'd9,  32'hCAFE,     32'h0,        32'h0};
        vecs[2] = '{32'h1,        32'h7,       1'b1,1'b1,7'd3,  1'b1,1'b1,7'h48,32'hDEAD,    1'b0,64'h0,                 32'h108,      1'b1,7'h48, 32'hDEAD,     32'h0,        32'h0};
        vecs[3] = '{32'h55,       32'h0,       1'b0,1'b1,7'd0,  1'b0,1'b0,7'h00,32'h0,       1'b0,64'h0,                 32'h10C,      1'b0,7'd0,  32'h55,       32'h0,        32'h0};
        vecs[4] = '{32'h44,       32'h0,       1'b0,1'b0,7'd7,  1'b0,1'b0,7'h00,32'h0,       1'b0,64'h0,                 32'h110,      1'b0,7'd7,  32'h44,       32'h0,        32'h0};
        vecs[5] = '{32'h66,       32'h0,       1'b0,1'b0,7'd2,  1'b0,1'b0,7'h00,32'h0,       1'b1,64'h12345678_9ABCDEF0, 32'h114,      1'b0,7'd2,  32'h66,       32'h12345678, 32'h9ABCDEF0};
        vecs[6] = '{32'h77,       32'h0,       1'b0,1'b1,7'd31, 1'b0,1'b0,7'h00,32'h0,       1'b0,64'hFFFFFFFF_FFFFFFFF, 32'h118,      1'b1,7'd31, 32'h77,       32'h12345678, 32'h9ABCDEF0};
        vecs[7] = '{32'h88,       32'h99,      1'b0,1'b1,7'd6,  1'b1,1'b0,7'h7F,32'h1234,    1'b0,64'h0,                 32'h11C,      1'b1,7'h7F, 32'h88,       32'h12345678, 32'h9ABCDEF0};
        vecs[8] = '{32'hAA,       32'hBB,      1'b1,1'b1,7'd4,  1'b0,1'b1,7'h55,32'hBEEF,    1'b1,64'h00000001_00000002, 32'h120,      1'b1,7'd4,  32'hBEEF,     32'h1,        32'h2};

        idle_inputs();
        bus.out_ready = 1'b0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;

        // ---------------- table-driven single commits ----------------
        foreach (vecs[i]) begin
            @(negedge clk);
            idle_inputs();
            bus.in_valid     = 1'b1;
            bus.aluout       = vecs[i].aluout;
            bus.memdata      = vecs[i].memdata;
            bus.mem_to_reg   = vecs[i].mem_to_reg;
            bus.reg_write    = vecs[i].reg_write;
            bus.waddr        = vecs[i].waddr;
            bus.exc_addr_sel = vecs[i].exc_addr_sel;
            bus.exc_data_sel = vecs[i].exc_data_sel;
            bus.exc_addr     = vecs[i].exc_addr;
            bus.exc_data     = vecs[i].exc_data;
            bus.hilo_we      = vecs[i].hilo_we;
            bus.hilo_data    = vecs[i].hilo_data;
            bus.pc_in        = vecs[i].pc;
            bus.out_ready    = 1'b1;
            @(negedge clk);               // record pushed, now popping
            idle_inputs();
            check($sformatf("vec%0d.rf_we", i),    64'(bus.rf_we),    64'(vecs[i].exp_we));
            check($sformatf("vec%0d.rf_waddr", i), 64'(bus.rf_waddr), 64'(vecs[i].exp_waddr));
            check($sformatf("vec%0d.rf_wdata", i), 64'(bus.rf_wdata), 64'(vecs[i].exp_wdata));
            check($sformatf("vec%0d.pc_out", i),   64'(bus.pc_out),   64'(vecs[i].pc));
            @(negedge clk);               // popped
            exp_retire = exp_retire + 32'd1;
            check($sformatf("vec%0d.hi", i),         64'(bus.hi),         64'(vecs[i].exp_hi));
            check($sformatf("vec%0d.lo", i),         64'(bus.lo),         64'(vecs[i].exp_lo));
            check($sformatf("vec%0d.busy", i),       64'(bus.busy),       64'd0);
            check($sformatf("vec%0d.retire_cnt", i), 64'(bus.retire_cnt), 64'(exp_retire));
        end

        // ---------------- back-pressure: fill, overflow, drain ----------------
        bus.out_ready = 1'b0;
        offer(32'hA1, 7'd1, 32'h200);
        @(negedge clk);
        check("bp.in_ready_one", 64'(bus.in_ready), 64'd1);
        offer(32'hB2, 7'd2, 32'h204);
        @(negedge clk);
        check("bp.in_ready_full", 64'(bus.in_ready), 64'd0);
        check("bp.rf_we_stall",   64'(bus.rf_we),    64'd0);
        check("bp.head_waddr",    64'(bus.rf_waddr), 64'd1);
        offer(32'hC3, 7'd3, 32'h208);     // must be ignored
        @(negedge clk);
        check("bp.in_ready_held", 64'(bus.in_ready), 64'd0);
        idle_inputs();
        bus.out_ready = 1'b1;
        #1;
        check("bp.full_pop_in_ready", 64'(bus.in_ready), 64'd0);
        check("bp.pop1.rf_we",    64'(bus.rf_we),    64'd1);
        check("bp.pop1.rf_wdata", 64'(bus.rf_wdata), 64'hA1);
        @(negedge clk);
        exp_retire = exp_retire + 32'd1;
        check("bp.in_ready_after_pop", 64'(bus.in_ready), 64'd1);
        check("bp.pop2.rf_we",    64'(bus.rf_we),    64'd1);
        check("bp.pop2.rf_waddr", 64'(bus.rf_waddr), 64'd2);
        check("bp.pop2.rf_wdata", 64'(bus.rf_wdata), 64'hB2);
        @(negedge clk);
        exp_retire = exp_retire + 32'd1;
        check("bp.drained.busy",  64'(bus.busy),       64'd0);
        check("bp.drained.rf_we", 64'(bus.rf_we),      64'd0);
        check("bp.retire_cnt",    64'(bus.retire_cnt), 64'(exp_retire));

        // ---------------- flush with coincident pop ----------------
        bus.out_ready = 1'b0;
        offer(32'hD4, 7'd10, 32'h300);
        @(negedge clk);
        offer(32'hE5, 7'd11, 32'h304);
        @(negedge clk);
        offer(32'hF6, 7'd12, 32'h308);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("flush.pop.rf_we",    64'(bus.rf_we),    64'd1);
        check("flush.pop.rf_waddr", 64'(bus.rf_waddr), 64'd10);
        check("flush.pop.rf_wdata", 64'(bus.rf_wdata), 64'hD4);
        @(negedge clk);
        exp_retire = exp_retire + 32'd1;
        idle_inputs();
        check("flush.busy",       64'(bus.busy),       64'd0);
        check("flush.in_ready",   64'(bus.in_ready),   64'd1);
        check("flush.rf_waddr",   64'(bus.rf_waddr),   64'd0);
        check("flush.retire_cnt", 64'(bus.retire_cnt), 64'(exp_retire));

        // ---------------- flush suppresses a push that has room ----------------
        bus.out_ready = 1'b0;
        offer(32'h1111, 7'd13, 32'h400);
        @(negedge clk);
        offer(32'h2222, 7'd14, 32'h404);
        bus.flush = 1'b1;
        #1;
        check("flush2.rf_we", 64'(bus.rf_we), 64'd0);
        @(negedge clk);
        idle_inputs();
        check("flush2.busy",       64'(bus.busy),       64'd0);
        check("flush2.retire_cnt", 64'(bus.retire_cnt), 64'(exp_retire));
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("flush2.no_ghost_pop", 64'(bus.busy), 64'd0);

        // ---------------- retire counter wrap ----------------
        #2;
        force dut.r_retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_cnt;
        @(negedge clk);
        check("wrap.preload", 64'(bus.retire_cnt), 64'hFFFF_FFFF);
        offer(32'h5A, 7'd8, 32'h500);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        check("wrap.retire_cnt", 64'(bus.retire_cnt), 64'd0);

        // ---------------- asynchronous reset mid-stream ----------------
        bus.out_ready = 1'b0;
        offer(32'h77, 7'd9, 32'h600);
        @(negedge clk);
        offer(32'h78, 7'd10, 32'h604);
        @(negedge clk);
        idle_inputs();
        bus.out_ready = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("midreset.rf_we_release", 64'(bus.rf_we), 64'd0);
        @(negedge clk);
        check("midreset.rf_we_after", 64'(bus.rf_we), 64'd0);
        check("midreset.busy_after",  64'(bus.busy),  64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_commit_stage.md
WB_COMMIT_STAGE -- requirements
Module: wb_commit_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data path width.
REQ-002 SHALL have parameter ADDR_W, default 7, register-file address width (GPR plus CP0/special space).
REQ-003 SHALL have parameter DEPTH, default 2, commit-buffer entries (power of two, at least 2).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, MEM stage offers a record.
REQ-007 SHALL have port in_ready, output, 1, buffer can accept a record.
REQ-008 SHALL have ports aluout and memdata, input, WIDTH each, result candidates.
REQ-009 SHALL have port mem_to_reg, input, 1; 1 selects memdata, 0 selects aluout.
REQ-010 SHALL have ports reg_write (input, 1) and waddr (input, ADDR_W), register-file write request.
REQ-011 SHALL have ports exc_addr_sel and exc_data_sel (input, 1 each), exc_addr (input, ADDR_W) and exc_data (input, WIDTH), exception overrides.
REQ-012 SHALL have ports hilo_we (input, 1), hilo_data (input, 64), and pc_in (input, 32).
REQ-013 SHALL have port flush, input, 1, discards all buffered records not popping this cycle.
REQ-014 SHALL have port out_ready, input, 1, commit sink accepts the head record.
REQ-015 SHALL have ports rf_we (output, 1), rf_waddr (output, ADDR_W), rf_wdata (output, WIDTH), and pc_out (output, 32).
REQ-016 SHALL have ports hi and lo, output, WIDTH each, architectural HI/LO registers.
REQ-017 SHALL have ports retire_cnt (output, 32) and busy (output, 1, buffer non-empty).

Function
REQ-018 SHALL compute the record on push: data = exc_data_sel ? exc_data : (mem_to_reg ? memdata : aluout), and addr = exc_addr_sel ? exc_addr : waddr.
REQ-019 SHALL store data, addr, reg_write, hilo_we, hilo_data and pc_in per entry in a circular FIFO with read/write pointers that wrap modulo DEPTH and an occupancy count of 0..DEPTH.
REQ-020 SHALL drive in_ready = (count < DEPTH), combinational from registered count only; push occurs when in_valid && in_ready.
REQ-021 SHALL pop when busy && out_ready; latency is 1 cycle, so a record pushed at edge N is poppable from cycle N+1.
REQ-022 SHALL on a pop cycle drive rf_we = head.reg_write && (head.addr != 0), with rf_waddr/rf_wdata/pc_out from the head entry.
REQ-023 SHALL hold rf_we = 0 when not popping, with rf_waddr/rf_wdata/pc_out keeping the head value (0 when empty).
REQ-024 SHALL on a pop with head.hilo_we load hi = hilo_data[63:32] and lo = hilo_data[31:0] (zero-extended or truncated to WIDTH) at that edge.
REQ-025 SHALL increment retire_cnt by 1 per pop, wrapping from 0xFFFFFFFF to 0.
REQ-026 SHALL on simultaneous push and pop change count by 0 and advance both pointers; when full, in_ready stays 0 in that cycle even if a pop occurs.
REQ-027 SHALL on flush set count to 0 and read pointer = write pointer, suppress any push in the same cycle, and still complete a coincident pop (rf write, HI/LO and retire_cnt update).

Reset
REQ-028 SHALL on resetn low, asynchronously, zero pointers, count, hi, lo and retire_cnt; outputs go to rf_we=0, busy=0, in_ready=1, rf_waddr=0, rf_wdata=0, pc_out=0.
REQ-029 SHALL on reset asserted mid-operation discard all buffered records, with no rf_we pulse in or after the reset cycle.

Verification
REQ-030 Bench SHALL check: push {aluout=0x11, mem_to_reg=0, waddr=5, reg_write=1}, out_ready=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x11, retire_cnt=1.
REQ-031 Bench SHALL check: out_ready=0, push 2 records -> in_ready=0, third push is ignored; raise out_ready -> records pop in order, in_ready=1 after first pop.
REQ-032 Bench SHALL check: push with exc_addr_sel=1, exc_data_sel=1, exc_addr=0x48, exc_data=0xDEAD -> rf_waddr=0x48, rf_wdata=0xDEAD; push waddr=0 with reg_write=1 -> rf_we=0.
REQ-033 Bench SHALL check: pop with hilo_we=1, hilo_data=0x12345678_9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0 next cycle; pop with hilo_we=0 -> hi/lo unchanged.
REQ-034 Bench SHALL check: 2 buffered, out_ready=1, flush=1, in_valid=1 -> head commits, busy=0 next cycle, incoming record dropped.
REQ-035 Bench SHALL check: retire_cnt forced near wrap (0xFFFFFFFF) -> one pop yields 0; resetn low mid-stream -> all outputs at reset values immediately.
